ldpc_dec_sched: RTL
===================

Name: ldpc_dec_sched

Overview:
- Job sequencer for the LDPC decoder datapath inside ldpcEncDec.
- Accepts one decode job at a time and streams NN channel bits into the decoder core in LOAD_W-bit beats.
- Runs min-sum iterations until the syndrome passes or the iteration budget is spent, then streams the corrected codeword out and raises a one-cycle interrupt.
- Sits between the Wishbone register/FIFO front-end and the decoder core.

Parameters:
NN, 208, codeword length in bits
MM, 168, parity-check rows (passed through for the syndrome width check only)
LOAD_W, 16, bits per load/unload beat
BEATS, 13, ceil(NN/LOAD_W); the last beat carries NN mod LOAD_W valid LSBs when nonzero
ITER_W, 8, iteration counter width
SUM_LEN, 32, syndrome weight width

Ports:
wb_clk_i  in  1  clock
wb_rst_n  in  1  synchronous active-low reset
job_valid  in  1  job request
job_ready  out  1  job accepted when valid&&ready
cfg_max_iter  in  ITER_W  iteration budget, sampled at job accept
cfg_early_stop  in  1  stop on first zero syndrome, sampled at job accept
abort  in  1  cancel current job
ld_valid  in  1  input beat valid
ld_ready  out  1  input beat accepted
ld_data  in  LOAD_W  channel bits
dec_ld_en  out  1  write strobe to decoder input RAM
dec_ld_addr  out  4  beat index
dec_ld_data  out  LOAD_W  registered copy of ld_data
dec_init  out  1  one-cycle pulse: clear message memories
dec_iter_start  out  1  one-cycle pulse: run one iteration
dec_iter_done  in  1  one-cycle pulse from core
dec_syn_weight  in  SUM_LEN  unsatisfied-check count, valid with dec_iter_done
dec_rd_addr  out  4  read beat index to core (1-cycle read latency)
dec_rd_data  in  LOAD_W  hard-decision bits
out_valid  out  1  output beat valid
out_ready  in  1  output beat taken
out_data  out  LOAD_W  corrected bits
out_last  out  1  marks beat BEATS-1
busy  out  1  state != IDLE
res_ok  out  1  last job ended with zero syndrome
res_iters  out  ITER_W  iterations executed by last job
res_aborted  out  1  last job was aborted
irq  out  1  one-cycle pulse at job completion or abort

Behaviour:
- Reset (wb_rst_n low at a clock edge), all outputs 0:
  - State forced to IDLE; counters cleared.
  - job_ready=0 during reset; job_ready=1 in IDLE.
  - Reset mid-job discards the job with no irq.
- States:
  - IDLE: job_ready=1. On valid&&ready, latch cfg_max_iter (0 treated as 1) and cfg_early_stop, clear res_*, go to LOAD.
  - LOAD: ld_ready=1. Each accepted beat registers dec_ld_data and dec_ld_addr=beat count; dec_ld_en is asserted the following cycle. After beat BEATS-1 is accepted, go to INIT.
  - INIT: dec_init for 1 cycle, then ITER.
  - ITER: dec_iter_start for 1 cycle, iteration counter +1 (saturating at 2^ITER_W-1), then WAIT.
  - WAIT: hold until dec_iter_done.
    - If dec_syn_weight==0 and early_stop: set res_ok=1, go to UNLOAD.
    - Else if count==max_iter: res_ok=(weight==0), go to UNLOAD.
    - Else go to ITER.
  - UNLOAD: issue dec_rd_addr 0..BEATS-1, at most one outstanding read plus a one-entry skid register. out_valid holds data until out_ready; dec_rd_addr advances only when the skid is free. out_last=1 on beat BEATS-1. After its handshake, go to DONE.
  - DONE: res_iters=count, irq pulse for 1 cycle, go to IDLE.
- abort:
  - Sampled in LOAD, INIT, ITER, WAIT, UNLOAD.
  - Next cycle: res_aborted=1, res_ok=0, res_iters=count, irq pulse, state IDLE.
  - A pending dec_iter_done arriving after abort is ignored.
  - abort in IDLE or DONE has no effect.
- Simultaneous events:
  - abort has priority over dec_iter_done in WAIT.
  - dec_iter_done outside WAIT is ignored.
  - A new job is not accepted in the cycle irq pulses.
- Last-beat masking:
  - Bits at and above NN mod LOAD_W of the last beat are zeroed on dec_ld_data and out_data.
  - When NN is a multiple of LOAD_W, no masking.
- Stability:
  - res_* outputs hold until the next job accept.
  - busy=1 from the cycle after accept through DONE.

Test Plan:
- Clean codeword: job with max_iter=10, early_stop=1; core returns weight 0 on the first iteration -> 1 dec_iter_start, res_ok=1, res_iters=1, 13 out beats with out_last on beat 12, one irq.
- Budget exhaust: max_iter=5, weight always 3 -> exactly 5 dec_iter_start pulses, res_ok=0, res_iters=5, output still unloaded.
- max_iter=0 with early_stop=0 and weight 0 -> 1 iteration, res_ok=1, res_iters=1.
- Backpressure: ld_valid toggled every other cycle, out_ready low for 7 cycles mid-unload -> no beat lost or duplicated; dec_ld_addr sequence 0..12; out_data matches dec_rd_data per address; upper 0 bits of beat 12 zero (208 mod 16 = 0, so no masking), then rerun with NN=200 -> bits [15:8] of beat 12 are 0.
- Abort in WAIT coincident with dec_iter_done -> res_aborted=1, res_ok=0, irq once, IDLE next cycle; the next job completes normally.
- wb_rst_n low during UNLOAD -> all outputs 0 the next cycle, no irq; job_ready=1 after release.

Source files
------------

// File: rtl/ldpc_dec_sched.sv
// Job sequencer for the LDPC decoder core: load channel beats, run min-sum
// iterations until the syndrome clears or the budget runs out, then unload.
module ldpc_dec_sched #(
   parameter int unsigned NN      = 208,
   parameter int unsigned MM      = 168,
   parameter int unsigned LOAD_W  = 16,
   parameter int unsigned BEATS   = 13,
   parameter int unsigned ITER_W  = 8,
   parameter int unsigned SUM_LEN = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [ITER_W-1:0]  cfg_max_iter,
   input  logic               cfg_early_stop,
   input  logic               abort,
   input  logic               ld_valid,
   output logic               ld_ready,
   input  logic [LOAD_W-1:0]  ld_data,
   output logic               dec_ld_en,
   output logic [3:0]         dec_ld_addr,
   output logic [LOAD_W-1:0]  dec_ld_data,
   output logic               dec_init,
   output logic               dec_iter_start,
   input  logic               dec_iter_done,
   input  logic [SUM_LEN-1:0] dec_syn_weight,
   output logic [3:0]         dec_rd_addr,
   input  logic [LOAD_W-1:0]  dec_rd_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LOAD_W-1:0]  out_data,
   output logic               out_last,
   output logic               busy,
   output logic               res_ok,
   output logic [ITER_W-1:0]  res_iters,
   output logic               res_aborted,
   output logic               irq
);

   localparam int unsigned AW  = 4;
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned REM = NN % LOAD_W;
   localparam logic [LOAD_W-1:0] LAST_MASK =
      (REM == 0) ? {LOAD_W{1'b1}} : LOAD_W'((64'd1 << REM) - 64'd1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(BEATS - 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

   // Elaboration guard: syndrome weight must hold MM, beat index fits 4 bits.
   if (SUM_LEN < $clog2(MM + 1) || BEATS > 16) begin : g_bad_params
      $error("ldpc_dec_sched: inconsistent parameters");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_INIT, S_ITER, S_WAIT, S_UNLOAD, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       beat_q, beat_d, rd_cnt_q, rd_cnt_d;
   logic [ITER_W-1:0]   count_q, count_d, max_q, max_d, res_iters_q, res_iters_d;
   logic                early_q, early_d, rd_act_q, rd_act_d, pend_q, pend_d;
   logic                skid_v_q, skid_v_d, skid_last_q, skid_last_d;
   logic [LOAD_W-1:0]   skid_data_q, skid_data_d;
   logic                job_ready_q, job_ready_d, ld_ready_q, ld_ready_d;
   logic                dec_ld_en_q, dec_ld_en_d, dec_init_q, dec_init_d;
   logic                dec_iter_start_q, dec_iter_start_d;
   logic [AW-1:0]       dec_ld_addr_q, dec_ld_addr_d, dec_rd_addr_q, dec_rd_addr_d;
   logic [LOAD_W-1:0]   dec_ld_data_q, dec_ld_data_d, out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                busy_q, busy_d, res_ok_q, res_ok_d;
   logic                res_aborted_q, res_aborted_d, irq_q, irq_d;
   logic [LOAD_W-1:0]   rd_word;
   logic                rd_last, out_pop;

   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      count_d       = count_q;
      max_d         = max_q;
      early_d       = early_q;
      rd_cnt_d      = rd_cnt_q;
      rd_act_d      = 1'b0;
      pend_d        = rd_act_q;
      skid_v_d      = skid_v_q;
      skid_data_d   = skid_data_q;
      skid_last_d   = skid_last_q;
      dec_ld_en_d   = 1'b0;
      dec_ld_addr_d = dec_ld_addr_q;
      dec_ld_data_d = dec_ld_data_q;
      dec_rd_addr_d = dec_rd_addr_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_last_d    = out_last_q;
      res_ok_d      = res_ok_q;
      res_iters_d   = res_iters_q;
      res_aborted_d = res_aborted_q;
      irq_d         = 1'b0;
      // Read address is held while its data is in flight, so it tags the returning word.
      rd_last       = (dec_rd_addr_q == LAST_IDX);
      rd_word       = rd_last ? (dec_rd_data & LAST_MASK) : dec_rd_data;
      out_pop       = out_valid_q && out_ready;

      case (state_q)
         S_IDLE: begin
            if (job_valid && job_ready_q) begin
               max_d         = (cfg_max_iter == '0) ? ITER_W'(1) : cfg_max_iter;
               early_d       = cfg_early_stop;
               res_ok_d      = 1'b0;
               res_iters_d   = '0;
               res_aborted_d = 1'b0;
               count_d       = '0;
               beat_d        = '0;
               state_d       = S_LOAD;
            end
         end
         S_LOAD: begin
            if (ld_valid && ld_ready_q) begin
               dec_ld_en_d   = 1'b1;
               dec_ld_addr_d = AW'(beat_q);
               dec_ld_data_d = (beat_q == LAST_BEAT) ? (ld_data & LAST_MASK) : ld_data;
               beat_d        = beat_q + CW'(1);
               if (beat_q == LAST_BEAT) state_d = S_INIT;
            end
         end
         S_INIT: state_d = S_ITER;
         S_ITER: begin
            if (count_q != {ITER_W{1'b1}}) count_d = count_q + ITER_W'(1);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dec_iter_done) begin
               if (dec_syn_weight == '0 && early_q) begin
                  res_ok_d = 1'b1;
                  state_d  = S_UNLOAD;
               end else if (count_q == max_q) begin
                  res_ok_d = (dec_syn_weight == '0);
                  state_d  = S_UNLOAD;
               end else begin
                  state_d  = S_ITER;
               end
            end
         end
         S_UNLOAD: begin
            // One read in flight at a time; issue only when the skid slot is empty.
            if (!rd_act_q && !pend_q && !skid_v_q && rd_cnt_q < CW'(BEATS)) begin
               rd_act_d      = 1'b1;
               dec_rd_addr_d = AW'(rd_cnt_q);
               rd_cnt_d      = rd_cnt_q + CW'(1);
            end
            if (!out_valid_q || out_pop) begin
               if (skid_v_q) begin
                  out_valid_d = 1'b1;
                  out_data_d  = skid_data_q;
                  out_last_d  = skid_last_q;
                  skid_v_d    = pend_q;
                  skid_data_d = rd_word;
                  skid_last_d = rd_last;
               end else if (pend_q) begin
                  out_valid_d = 1'b1;
                  out_data_d  = rd_word;
                  out_last_d  = rd_last;
               end else begin
                  out_valid_d = 1'b0;
               end
            end else if (pend_q) begin
               skid_v_d    = 1'b1;
               skid_data_d = rd_word;
               skid_last_d = rd_last;
            end
            if (out_pop && out_last_q) state_d = S_DONE;
         end
         S_DONE: begin
            res_iters_d = count_q;
            irq_d       = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && state_q inside {S_LOAD, S_INIT, S_ITER, S_WAIT, S_UNLOAD}) begin
         state_d       = S_IDLE;
         dec_ld_en_d   = 1'b0;
         res_aborted_d = 1'b1;
         res_ok_d      = 1'b0;
         res_iters_d   = count_q;
         irq_d         = 1'b1;
      end

      if (state_d != S_UNLOAD) begin
         rd_cnt_d    = '0;
         rd_act_d    = 1'b0;
         pend_d      = 1'b0;
         skid_v_d    = 1'b0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      job_ready_d      = (state_d == S_IDLE) && !irq_d;
      ld_ready_d       = (state_d == S_LOAD);
      dec_init_d       = (state_d == S_INIT);
      dec_iter_start_d = (state_d == S_ITER);
      busy_d           = (state_d != S_IDLE);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q          <= S_IDLE;
         beat_q           <= '0;
         count_q          <= '0;
         max_q            <= '0;
         early_q          <= 1'b0;
         rd_cnt_q         <= '0;
         rd_act_q         <= 1'b0;
         pend_q           <= 1'b0;
         skid_v_q         <= 1'b0;
         skid_data_q      <= '0;
         skid_last_q      <= 1'b0;
         job_ready_q      <= 1'b0;
         ld_ready_q       <= 1'b0;
         dec_ld_en_q      <= 1'b0;
         dec_ld_addr_q    <= '0;
         dec_ld_data_q    <= '0;
         dec_init_q       <= 1'b0;
         dec_iter_start_q <= 1'b0;
         dec_rd_addr_q    <= '0;
         out_valid_q      <= 1'b0;
         out_data_q       <= '0;
         out_last_q       <= 1'b0;
         busy_q           <= 1'b0;
         res_ok_q         <= 1'b0;
         res_iters_q      <= '0;
         res_aborted_q    <= 1'b0;
         irq_q            <= 1'b0;
      end else begin
         state_q          <= state_d;
         beat_q           <= beat_d;
         count_q          <= count_d;
         max_q            <= max_d;
         early_q          <= early_d;
         rd_cnt_q         <= rd_cnt_d;
         rd_act_q         <= rd_act_d;
         pend_q           <= pend_d;
         skid_v_q         <= skid_v_d;
         skid_data_q      <= skid_data_d;
         skid_last_q      <= skid_last_d;
         job_ready_q      <= job_ready_d;
         ld_ready_q       <= ld_ready_d;
         dec_ld_en_q      <= dec_ld_en_d;
         dec_ld_addr_q    <= dec_ld_addr_d;
         dec_ld_data_q    <= dec_ld_data_d;
         dec_init_q       <= dec_init_d;
         dec_iter_start_q <= dec_iter_start_d;
         dec_rd_addr_q    <= dec_rd_addr_d;
         out_valid_q      <= out_valid_d;
         out_data_q       <= out_data_d;
         out_last_q       <= out_last_d;
         busy_q           <= busy_d;
         res_ok_q         <= res_ok_d;
         res_iters_q      <= res_iters_d;
         res_aborted_q    <= res_aborted_d;
         irq_q            <= irq_d;
      end
   end

   assign job_ready      = job_ready_q;
   assign ld_ready       = ld_ready_q;
   assign dec_ld_en      = dec_ld_en_q;
   assign dec_ld_addr    = dec_ld_addr_q;
   assign dec_ld_data    = dec_ld_data_q;
   assign dec_init       = dec_init_q;
   assign dec_iter_start = dec_iter_start_q;
   assign dec_rd_addr    = dec_rd_addr_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_last       = out_last_q;
   assign busy           = busy_q;
   assign res_ok         = res_ok_q;
   assign res_iters      = res_iters_q;
   assign res_aborted    = res_aborted_q;
   assign irq            = irq_q;

endmodule
